demux_1to4: RTL and testbench

DEMUX_1TO4 -- requirements
Module: demux_1to4

---
 rtl/demux_pkg.sv | 15 +
 rtl/demux_1to2.sv | 23 ++
 rtl/demux_1to4.sv | 123 ++++++++++++
 tb/tb_demux_1to4.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 demultiplexer: route-index encoding
// and default widths.
package demux_pkg;

    typedef logic [1:0] route_idx_t;

    localparam route_idx_t IDX_Y0 = 2'd0;
    localparam route_idx_t IDX_Y1 = 2'd1;
    localparam route_idx_t IDX_Y2 = 2'd2;
    localparam route_idx_t IDX_Y3 = 2'd3;

    localparam int unsigned DEF_DATA_W = 32'd1;
    localparam int unsigned DEF_CNT_W  = 32'd8;

endpackage : demux_pkg

// File: rtl/demux_1to2.sv
// Combinational 1-to-2 demux stage: din goes to y1 when sel is high,
// to y0 otherwise; the unselected leg is driven to zero.
module demux_1to2 #(
    parameter int unsigned DATA_W = 32'd1
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] y0,
    output logic [DATA_W-1:0] y1
);

    // steer din onto one leg, zero the other
    always_comb begin
        y0 = '0;
        y1 = '0;
        if (sel) begin
            y1 = din;
        end else begin
            y0 = din;
        end
    end

endmodule : demux_1to2

// File: rtl/demux_1to4.sv
// Registered 1-to-4 demultiplexer built from a tree of demux_1to2 stages.
// Optional per-output saturating hit counters under DEMUX_HIT_CNT_EN.
module demux_1to4
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              Sel0,
    input  logic              Sel1,
    input  logic [DATA_W-1:0] Inp,
    output logic [DATA_W-1:0] Y0,
    output logic [DATA_W-1:0] Y1,
    output logic [DATA_W-1:0] Y2,
    output logic [DATA_W-1:0] Y3
`ifdef DEMUX_HIT_CNT_EN
    ,
    output logic [CNT_W-1:0]  hit_cnt0,
    output logic [CNT_W-1:0]  hit_cnt1,
    output logic [CNT_W-1:0]  hit_cnt2,
    output logic [CNT_W-1:0]  hit_cnt3
`endif
);

    logic [DATA_W-1:0] w_lo;
    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_y [4];
    logic [DATA_W-1:0] r_y [4];

    // MSB first splits Y0/Y1 from Y2/Y3, then the LSB picks within each pair
    demux_1to2 #(.DATA_W(DATA_W)) u_stage_msb (
        .sel (Sel1),
        .din (Inp),
        .y0  (w_lo),
        .y1  (w_hi)
    );

    demux_1to2 #(.DATA_W(DATA_W)) u_stage_lsb_lo (
        .sel (Sel0),
        .din (w_lo),
        .y0  (w_y[0]),
        .y1  (w_y[1])
    );

    demux_1to2 #(.DATA_W(DATA_W)) u_stage_lsb_hi (
        .sel (Sel0),
        .din (w_hi),
        .y0  (w_y[2]),
        .y1  (w_y[3])
    );

    // output registers: reset wins, enable captures the routed word, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_y[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < 4; k++) begin
                r_y[k] <= w_y[k];
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                r_y[k] <= r_y[k];
            end
        end
    end

    assign Y0 = r_y[0];
    assign Y1 = r_y[1];
    assign Y2 = r_y[2];
    assign Y3 = r_y[3];

`ifdef DEMUX_HIT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    route_idx_t w_idx;
    logic [3:0] w_hit;
    logic [CNT_W-1:0] r_cnt [4];

    assign w_idx = {Sel1, Sel0};

    // a hit is a nonzero word routed to that output
    always_comb begin
        w_hit    = 4'b0000;
        w_hit[0] = (w_idx == IDX_Y0) && (|Inp);
        w_hit[1] = (w_idx == IDX_Y1) && (|Inp);
        w_hit[2] = (w_idx == IDX_Y2) && (|Inp);
        w_hit[3] = (w_idx == IDX_Y3) && (|Inp);
    end

    // saturating hit counters, updated alongside the output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_cnt[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < 4; k++) begin
                if (w_hit[k] && (r_cnt[k] != CNT_MAX)) begin
                    r_cnt[k] <= r_cnt[k] + CNT_ONE;
                end else begin
                    r_cnt[k] <= r_cnt[k];
                end
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                r_cnt[k] <= r_cnt[k];
            end
        end
    end

    assign hit_cnt0 = r_cnt[0];
    assign hit_cnt1 = r_cnt[1];
    assign hit_cnt2 = r_cnt[2];
    assign hit_cnt3 = r_cnt[3];
`endif

endmodule : demux_1to4

// File: tb/tb_demux_1to4.sv
// Self-checking bench for demux_1to4: vector table with hand-derived
// expected outputs fed through a scoreboard queue; counters checked when
// DEMUX_HIT_CNT_EN is defined.
module tb_demux_1to4;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          Sel0;
    logic          Sel1;
    logic [DW-1:0] Inp;
    logic [DW-1:0] Y0, Y1, Y2, Y3;
`ifdef DEMUX_HIT_CNT_EN
    logic [CW-1:0] hit_cnt0, hit_cnt1, hit_cnt2, hit_cnt3;
`endif

    demux_1to4 #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .Sel0 (Sel0),
        .Sel1 (Sel1),
        .Inp  (Inp),
        .Y0   (Y0),
        .Y1   (Y1),
        .Y2   (Y2),
        .Y3   (Y3)
`ifdef DEMUX_HIT_CNT_EN
        ,
        .hit_cnt0 (hit_cnt0),
        .hit_cnt1 (hit_cnt1),
        .hit_cnt2 (hit_cnt2),
        .hit_cnt3 (hit_cnt3)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               rst;
        logic               en;
        logic               sel1;
        logic               sel0;
        logic [DW-1:0]      inp;
        logic [3:0][DW-1:0] exp_y;
    } vec_t;

    vec_t               tbl [$];
    logic [3:0][DW-1:0] exp_q [$];
    int                 cnt_q [$];
    int                 n_checks = 0;
    int                 n_fail   = 0;
    int                 mdl_cnt [4];

    function automatic vec_t mk(input logic r, input logic e, input logic s1,
                                input logic s0, input logic [DW-1:0] d,
                                input logic [DW-1:0] y0, input logic [DW-1:0] y1,
                                input logic [DW-1:0] y2, input logic [DW-1:0] y3);
        vec_t v;
        v.rst   = r;
        v.en    = e;
        v.sel1  = s1;
        v.sel0  = s0;
        v.inp   = d;
        v.exp_y = {y3, y2, y1, y0};
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // drive one vector, push expectations, then compare one clock later
    task automatic apply(input vec_t v, input int step);
        logic [3:0][DW-1:0] e;
        logic [DW-1:0]      got [4];
        int                 idx;
        @(negedge clk);
        rst  = v.rst;
        en   = v.en;
        Sel1 = v.sel1;
        Sel0 = v.sel0;
        Inp  = v.inp;
        exp_q.push_back(v.exp_y);
        idx = {30'd0, v.sel1, v.sel0};
        if (v.rst) begin
            for (int k = 0; k < 4; k++) mdl_cnt[k] = 0;
        end else if (v.en && (v.inp != '0) && (mdl_cnt[idx] < 3)) begin
            mdl_cnt[idx] = mdl_cnt[idx] + 1;
        end
        for (int k = 0; k < 4; k++) cnt_q.push_back(mdl_cnt[k]);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        got[0] = Y0; got[1] = Y1; got[2] = Y2; got[3] = Y3;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("step%0d_Y%0d", step, k), int'(got[k]), int'(e[k]));
        end
`ifdef DEMUX_HIT_CNT_EN
        check($sformatf("step%0d_hit_cnt0", step), int'(hit_cnt0), cnt_q.pop_front());
        check($sformatf("step%0d_hit_cnt1", step), int'(hit_cnt1), cnt_q.pop_front());
        check($sformatf("step%0d_hit_cnt2", step), int'(hit_cnt2), cnt_q.pop_front());
        check($sformatf("step%0d_hit_cnt3", step), int'(hit_cnt3), cnt_q.pop_front());
`else
        cnt_q.delete();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; Sel0 = 1'b0; Sel1 = 1'b0; Inp = '0;
        for (int k = 0; k < 4; k++) mdl_cnt[k] = 0;

        // reset held with live inputs
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00));
        // sweep (Sel0,Sel1,Inp) = 000..111
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01));
        // hold: 1 to Y2, then disabled with select/data changed
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00));
        // select switch Y3 -> Y0 with wide data
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'h00));
        // mid-stream reset, then resume on a different output
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h00, 8'h5A, 8'h00, 8'h00));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 8'h00, 8'h00, 8'h11, 8'h00));
        // reset with en low still clears
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // counter saturation: 5 hits to Y1, then 2 zero words
        for (int i = 0; i < 5; i++) begin
            apply(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00), 100 + i);
        end
        for (int i = 0; i < 2; i++) begin
            apply(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00), 110 + i);
        end
`ifdef DEMUX_HIT_CNT_EN
        check("sat_hit_cnt1", int'(hit_cnt1), 3);
        check("sat_hit_cnt0", int'(hit_cnt0), 0);
        check("sat_hit_cnt2", int'(hit_cnt2), 0);
        check("sat_hit_cnt3", int'(hit_cnt3), 0);
`endif
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_demux_1to4
